// File: rtl/branch_resolve_unit.sv
// Branch resolve unit paired with a gshare predictor: owns the speculative GHR, carries
// per-branch prediction state F->D->E, resolves in E and drives PHT update and flush.
// Optional BRU_STATS_EN adds saturating resolved/mispredicted branch counters.
module branch_resolve_unit #(
  parameter int unsigned HIST_W = 4,
  parameter int unsigned PC_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_valid,
  input  logic              f_is_branch,
  input  logic [PC_W-1:0]   f_pc,
  input  logic              f_pred,
  output logic [HIST_W-1:0] f_ghr,
  input  logic              stall,
  input  logic              e_branch,
  input  logic              e_taken,
  input  logic [PC_W-1:0]   e_target,
  output logic              upd_en,
  output logic [HIST_W-1:0] upd_idx,
  output logic              upd_taken,
  output logic              flush,
  output logic [PC_W-1:0]   redirect_pc
`ifdef BRU_STATS_EN
  ,
  output logic [15:0]       br_count,
  output logic [15:0]       mis_count
`endif
);

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  // Only the low bits of the checkpoint are needed: recovery shifts the MSB out anyway.
  typedef struct packed {
    logic              valid;
    logic              is_branch;
    logic              pred;
    logic [HIST_W-1:0] idx;
    logic [HIST_W-2:0] ckpt;
    logic [PC_W-1:0]   pc;
  } slot_t;

  state_e            state_q, state_d;
  logic [HIST_W-1:0] ghr_q, ghr_d;
  slot_t             d_slot_q, d_slot_d;
  slot_t             e_slot_q, e_slot_d;
  logic [PC_W-1:0]   redirect_q, redirect_d;
  logic              upd_en_q, upd_taken_q, flush_q;
  logic [HIST_W-1:0] upd_idx_q;

  logic fetch_acc, res, mis;

  assign fetch_acc = f_valid & ~stall & (state_q == StRun);
  assign res       = e_branch & e_slot_q.valid;
  assign mis       = res & (e_taken != e_slot_q.pred);

  always_comb begin
    state_d    = state_q;
    ghr_d      = ghr_q;
    d_slot_d   = d_slot_q;
    e_slot_d   = e_slot_q;
    redirect_d = redirect_q;
    if (mis) begin
      // Recover history from the checkpoint; any same-cycle fetch is discarded.
      ghr_d          = {e_slot_q.ckpt, e_taken};
      d_slot_d.valid = 1'b0;
      e_slot_d.valid = 1'b0;
      redirect_d     = e_taken ? e_target : e_slot_q.pc + PC_W'(1);
      state_d        = StFlush;
    end else begin
      if (state_q == StFlush) begin
        state_d = StRun;
      end
      if (stall) begin
        e_slot_d.valid = 1'b0;
      end else begin
        e_slot_d           = d_slot_q;
        d_slot_d.valid     = fetch_acc;
        d_slot_d.is_branch = f_is_branch;
        d_slot_d.pred      = f_pred;
        d_slot_d.idx       = f_pc[HIST_W-1:0] ^ ghr_q;
        d_slot_d.ckpt      = ghr_q[HIST_W-2:0];
        d_slot_d.pc        = f_pc;
        if (fetch_acc && f_is_branch) begin
          ghr_d = {ghr_q[HIST_W-2:0], f_pred};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StRun;
      ghr_q       <= '0;
      d_slot_q    <= '0;
      e_slot_q    <= '0;
      redirect_q  <= '0;
      upd_en_q    <= 1'b0;
      upd_idx_q   <= '0;
      upd_taken_q <= 1'b0;
      flush_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ghr_q       <= ghr_d;
      d_slot_q    <= d_slot_d;
      e_slot_q    <= e_slot_d;
      redirect_q  <= redirect_d;
      upd_en_q    <= res;
      upd_idx_q   <= e_slot_q.idx;
      upd_taken_q <= e_taken;
      flush_q     <= mis;
    end
  end

  assign f_ghr       = ghr_q;
  assign upd_en      = upd_en_q;
  assign upd_idx     = upd_idx_q;
  assign upd_taken   = upd_taken_q;
  assign flush       = flush_q;
  assign redirect_pc = redirect_q;

`ifdef BRU_STATS_EN
  logic [15:0] br_count_q, mis_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      br_count_q  <= '0;
      mis_count_q <= '0;
    end else begin
      if (res && br_count_q != 16'hFFFF) begin
        br_count_q <= br_count_q + 16'd1;
      end
      if (mis && mis_count_q != 16'hFFFF) begin
        mis_count_q <= mis_count_q + 16'd1;
      end
    end
  end

  assign br_count  = br_count_q;
  assign mis_count = mis_count_q;
`endif

  // A valid slot resolving as a branch must have been fetched as one.
  a_e_is_branch : assert property (@(posedge clk) disable iff (reset)
    (e_branch && e_slot_q.valid) |-> e_slot_q.is_branch);

endmodule
